// File: rtl/sha1_block_engine.sv
// sha1_block_engine
//   Iterative SHA-1 compression engine fed by a word-streaming load port.
//   A block arrives as 16 big-endian 32-bit words (W0 first). The engine then
//   runs 80 rounds, UNROLL rounds per clock, and folds the result into the
//   chaining value. The chaining value carries over to the next block unless
//   that block starts with iInitial, which reloads the SHA-1 IV.
//
// Parameters
//   UNROLL   SHA-1 rounds per compute cycle (1, 2, 4 or 5)
//
// Ports
//   clk       rising-edge clock
//   reset     synchronous active-high reset
//   iInitial  with iValid: word 0 of a new message, restart from the IV
//   iValid    iDat holds a message word this cycle
//   iDat      32-bit message word
//   oReady    engine idle and accepting words
//   oDat      digest of the last completed block, H0 in [159:128]
module sha1_block_engine #(
    parameter int UNROLL = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         iInitial,
    input  logic         iValid,
    input  logic [31:0]  iDat,
    output logic         oReady,
    output logic [159:0] oDat
);

    typedef enum logic [1:0] {LOAD, COMPUTE, FINALIZE} state_t;

    localparam logic [31:0] IV0 = 32'h67452301;
    localparam logic [31:0] IV1 = 32'hEFCDAB89;
    localparam logic [31:0] IV2 = 32'h98BADCFE;
    localparam logic [31:0] IV3 = 32'h10325476;
    localparam logic [31:0] IV4 = 32'hC3D2E1F0;

    // Round index of the first round in the final compute cycle.
    localparam logic [6:0] LAST_T = 7'(80 - UNROLL);

    function automatic logic [31:0] rotl1(input logic [31:0] x);
        return {x[30:0], x[31]};
    endfunction

    function automatic logic [31:0] rotl5(input logic [31:0] x);
        return {x[26:0], x[31:27]};
    endfunction

    function automatic logic [31:0] rotl30(input logic [31:0] x);
        return {x[1:0], x[31:2]};
    endfunction

    function automatic logic [31:0] fFunc(input logic [6:0] rt, input logic [31:0] b,
                                          input logic [31:0] c, input logic [31:0] d);
        if (rt < 7'd20)
            return (b & c) | (~b & d);
        else if (rt < 7'd40 || rt >= 7'd60)
            return b ^ c ^ d;
        else
            return (b & c) | (b & d) | (c & d);
    endfunction

    function automatic logic [31:0] kConst(input logic [6:0] rt);
        if (rt < 7'd20)
            return 32'h5A827999;
        else if (rt < 7'd40)
            return 32'h6ED9EBA1;
        else if (rt < 7'd60)
            return 32'h8F1BBCDC;
        else
            return 32'hCA62C1D6;
    endfunction

    state_t      state, stateNext;
    logic [3:0]  count;
    logic        useIv;
    logic [6:0]  t;
    logic [31:0] h0, h1, h2, h3, h4;
    logic [31:0] a, b, c, d, e;
    logic [31:0] w [16];

    logic [31:0] wNext [16];
    logic [31:0] aN, bN, cN, dN, eN;
    logic [6:0]  rt;
    logic [31:0] wt, temp;
    logic [31:0] s0, s1, s2, s3, s4;
    logic        lastWord;

    assign oReady = (state == LOAD);

    // The 16th word of a block, unless it is itself a restart.
    assign lastWord = iValid && !iInitial && (count == 4'd15);

    assign s0 = h0 + a;
    assign s1 = h1 + b;
    assign s2 = h2 + c;
    assign s3 = h3 + d;
    assign s4 = h4 + e;

    // UNROLL rounds chained combinationally. The schedule is expanded in place
    // on a working copy so a word produced by an early round of this cycle is
    // visible to the later rounds that need it as W[t-3].
    always_comb begin
        wNext = w;
        aN    = a;
        bN    = b;
        cN    = c;
        dN    = d;
        eN    = e;
        rt    = t;
        wt    = '0;
        temp  = '0;
        for (int k = 0; k < UNROLL; k++) begin
            rt = t + 7'(k);
            if (rt >= 7'd16)
                wNext[rt[3:0]] = rotl1(wNext[rt[3:0] - 4'd3] ^ wNext[rt[3:0] - 4'd8] ^
                                       wNext[rt[3:0] - 4'd14] ^ wNext[rt[3:0]]);
            wt   = wNext[rt[3:0]];
            temp = rotl5(aN) + fFunc(rt, bN, cN, dN) + eN + kConst(rt) + wt;
            eN   = dN;
            dN   = cN;
            cN   = rotl30(bN);
            bN   = aN;
            aN   = temp;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            LOAD:     if (lastWord) stateNext = COMPUTE;
            COMPUTE:  if (t == LAST_T) stateNext = FINALIZE;
            FINALIZE: stateNext = LOAD;
            default:  stateNext = LOAD;
        endcase
    end

    // Control and chaining state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LOAD;
            count <= 4'd0;
            useIv <= 1'b0;
            t     <= 7'd0;
            h0    <= IV0;
            h1    <= IV1;
            h2    <= IV2;
            h3    <= IV3;
            h4    <= IV4;
            oDat  <= '0;
        end else begin
            state <= stateNext;
            case (state)
                LOAD: begin
                    if (iValid) begin
                        if (iInitial) begin
                            count <= 4'd1;
                            useIv <= 1'b1;
                        end else begin
                            count <= count + 4'd1;
                        end
                    end
                    if (lastWord) begin
                        t <= 7'd0;
                        if (useIv) begin
                            h0 <= IV0;
                            h1 <= IV1;
                            h2 <= IV2;
                            h3 <= IV3;
                            h4 <= IV4;
                        end
                    end
                end
                COMPUTE: begin
                    t <= t + 7'(UNROLL);
                end
                FINALIZE: begin
                    h0    <= s0;
                    h1    <= s1;
                    h2    <= s2;
                    h3    <= s3;
                    h4    <= s4;
                    oDat  <= {s0, s1, s2, s3, s4};
                    useIv <= 1'b0;
                    count <= 4'd0;
                end
                default: ;
            endcase
        end
    end

    // Message buffer and working variables; contents are don't-care until a
    // block has been loaded, so they carry no reset.
    always_ff @(posedge clk) begin
        case (state)
            LOAD: begin
                if (iValid)
                    w[iInitial ? 4'd0 : count] <= iDat;
                if (lastWord) begin
                    a <= useIv ? IV0 : h0;
                    b <= useIv ? IV1 : h1;
                    c <= useIv ? IV2 : h2;
                    d <= useIv ? IV3 : h3;
                    e <= useIv ? IV4 : h4;
                end
            end
            COMPUTE: begin
                w <= wNext;
                a <= aN;
                b <= bN;
                c <= cN;
                d <= dN;
                e <= eN;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sha1_block_engine.sv
// tb_sha1_block_engine
//   Directed bench for sha1_block_engine. The stimulus process queues the
//   expected digest of each block it sends; the monitor pops an entry every
//   time oReady returns high and checks the digest and the busy length.
module tb_sha1_block_engine;

    localparam int UNROLL     = 1;
    localparam int LOW_EXPECT = 80 / UNROLL + 1;

    localparam logic [159:0] DIG_EMPTY = 160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709;
    localparam logic [159:0] DIG_ABC   = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
    localparam logic [159:0] DIG_TWO   = 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;

    logic         clk = 1'b0;
    logic         reset;
    logic         iInitial;
    logic         iValid;
    logic [31:0]  iDat;
    logic         oReady;
    logic [159:0] oDat;

    typedef struct {
        logic [159:0] digest;
        bit           checkDigest;
        string        name;
    } exp_t;

    exp_t sb[$];
    int   nCompared = 0;
    int   nMismatch = 0;

    logic [31:0] emptyBlk [16] = '{32'h80000000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                                   32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    logic [31:0] abcBlk [16]   = '{32'h61626380, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                                   32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h00000018};
    logic [31:0] twoBlkA [16]  = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                   32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                   32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                   32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    logic [31:0] twoBlkB [16]  = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                                   32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h000001c0};

    sha1_block_engine #(.UNROLL(UNROLL)) dut (
        .clk      (clk),
        .reset    (reset),
        .iInitial (iInitial),
        .iValid   (iValid),
        .iDat     (iDat),
        .oReady   (oReady),
        .oDat     (oDat)
    );

    always #5 clk = ~clk;

    task automatic checkVec(input string name, input logic [159:0] act, input logic [159:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatch++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkInt(input string name, input int act, input int exp);
        nCompared++;
        if (act != exp) begin
            nMismatch++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitReady();
        int n = 0;
        while (oReady !== 1'b1 && n < 500) begin
            tick();
            n++;
        end
        if (oReady !== 1'b1) begin
            nCompared++;
            nMismatch++;
            $display("FAIL waitReady: oReady still %b after %0d cycles", oReady, n);
        end
    endtask

    task automatic sendWord(input logic [31:0] dat, input logic init);
        iValid   = 1'b1;
        iInitial = init;
        iDat     = dat;
        tick();
        iValid   = 1'b0;
        iInitial = 1'b0;
        iDat     = '0;
    endtask

    // gapAt < 16 inserts one idle cycle carrying iInitial without iValid
    // before that word; it must not disturb the block.
    task automatic sendBlock(input logic [31:0] blk [16], input logic init, input int gapAt);
        waitReady();
        for (int i = 0; i < 16; i++) begin
            if (i == gapAt) begin
                iInitial = 1'b1;
                tick();
                iInitial = 1'b0;
            end
            sendWord(blk[i], init && (i == 0));
        end
    endtask

    task automatic expectBlock(input logic [159:0] dig, input bit chk, input string name);
        exp_t ent;
        ent.digest      = dig;
        ent.checkDigest = chk;
        ent.name        = name;
        sb.push_back(ent);
    endtask

    // Monitor: one scoreboard entry per return of oReady.
    initial begin : monitor
        int   lowCnt;
        bit   prevReady;
        exp_t ent;
        lowCnt    = 0;
        prevReady = 1'b1;
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                lowCnt    = 0;
                prevReady = 1'b1;
            end else begin
                if (oReady !== 1'b1) begin
                    lowCnt++;
                end else if (!prevReady) begin
                    if (sb.size() == 0) begin
                        nCompared++;
                        nMismatch++;
                        $display("FAIL unexpected_done: got digest %h expected no completion", oDat);
                    end else begin
                        ent = sb.pop_front();
                        if (ent.checkDigest)
                            checkVec({ent.name, "_digest"}, oDat, ent.digest);
                        checkInt({ent.name, "_busy_cycles"}, lowCnt, LOW_EXPECT);
                    end
                    lowCnt = 0;
                end
                prevReady = (oReady === 1'b1);
            end
        end
    end

    initial begin : stimulus
        int n;
        reset    = 1'b1;
        iValid   = 1'b0;
        iInitial = 1'b0;
        iDat     = '0;
        repeat (3) tick();
        checkInt("reset_ready", int'(oReady), 1);
        checkVec("reset_odat", oDat, '0);
        reset = 1'b0;
        tick();

        // Empty message
        expectBlock(DIG_EMPTY, 1'b1, "empty");
        sendBlock(emptyBlk, 1'b1, 16);

        // "abc" then the same block again in the first ready cycle
        expectBlock(DIG_ABC, 1'b1, "abc");
        sendBlock(abcBlk, 1'b1, 16);
        expectBlock(DIG_ABC, 1'b1, "abc_b2b");
        sendBlock(abcBlk, 1'b1, 16);

        // Two-block message, chaining into the second block
        expectBlock('0, 1'b0, "two_blk1");
        sendBlock(twoBlkA, 1'b1, 16);
        expectBlock(DIG_TWO, 1'b1, "two_blk2");
        sendBlock(twoBlkB, 1'b0, 16);

        // Junk words while computing must be dropped
        expectBlock(DIG_ABC, 1'b1, "abc_junk");
        sendBlock(abcBlk, 1'b1, 16);
        for (int i = 0; i < 80 / UNROLL - 4; i++) begin
            iValid   = 1'b1;
            iInitial = i[0];
            iDat     = 32'hDEAD0000 + 32'(i);
            tick();
        end
        iValid   = 1'b0;
        iInitial = 1'b0;
        iDat     = '0;

        // Reset at round 40 aborts the block
        sendBlock(abcBlk, 1'b1, 16);
        repeat (40 / UNROLL) tick();
        reset = 1'b1;
        tick();
        checkInt("abort_ready", int'(oReady), 1);
        checkVec("abort_odat", oDat, '0);
        reset = 1'b0;

        // After reset the IV is back, no iInitial needed; a stray iInitial
        // without iValid mid-block is ignored
        expectBlock(DIG_ABC, 1'b1, "abc_after_reset");
        sendBlock(abcBlk, 1'b0, 6);

        // Partial block discarded by iInitial at word 7
        waitReady();
        for (int i = 0; i < 7; i++)
            sendWord(32'h11111111 * 32'(i + 1), i == 0);
        expectBlock(DIG_ABC, 1'b1, "abc_restart");
        sendBlock(abcBlk, 1'b1, 16);

        n = 0;
        while (sb.size() != 0 && n < 500) begin
            tick();
            n++;
        end
        checkInt("scoreboard_drained", sb.size(), 0);
        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule

// File: doc/sha1_block_engine.md
Name: sha1_block_engine

Overview:
- Responder end of the word-streaming SHA-1 load interface that the collision searcher drives (valid/initial/32-bit data, then wait for ready).
- Accepts one 512-bit block as 16 sequential 32-bit words and runs the SHA-1 compression function iteratively.
- Publishes the 160-bit chaining value/digest and a ready flag.
- Supports multi-block messages by chaining unless a block begins with initial asserted.

Parameters:
- UNROLL, default 1: SHA-1 rounds per compute cycle. Legal values are 1, 2, 4 and 5. Compute phase lasts 80/UNROLL cycles.

Ports:
- clk  input  1  Rising-edge clock.
- reset  input  1  Synchronous, active-high reset.
- iInitial  input  1  Qualified by iValid. Marks word 0 of a new message; the chaining value is reloaded with the IV.
- iValid  input  1  iDat carries a message word this cycle.
- iDat  input  32  Message word, big-endian SHA-1 order (W0 first).
- oReady  output  1  High when the engine is idle and accepting words.
- oDat  output  160  Digest of last completed block. H0 is in [159:128] and H4 is in [31:0].

Behaviour:
- Reset (synchronous):
  - State LOAD, word count 0, oReady=1, oDat=0.
  - Chaining H0..H4 = IV: 67452301, EFCDAB89, 98BADCFE, 10325476, C3D2E1F0.
  - Reset mid-compute aborts the block with no digest update.
- States: LOAD, COMPUTE, FINALIZE.
- LOAD (oReady=1):
  - Each cycle with iValid=1, iDat is written to W[count] and count increments.
  - iValid with iInitial=1 forces the word into W[0], sets count=1 and latches "use IV" for this block.
  - iInitial=1 mid-block (count!=0) restarts the block, discarding partial words.
  - iInitial without iValid is ignored.
  - When the 16th word (count==15) is accepted, go to COMPUTE next cycle. oReady drops the cycle after the edge that captured word 15.
- Block start:
  - If "use IV" is set, a..e and the chaining registers load the IV. Otherwise a..e load the current H0..H4 (chaining).
- COMPUTE (oReady=0):
  - Round counter t runs 0..79 in steps of UNROLL.
  - Per round: TEMP = rotl5(a) + f(t) + e + K(t) + W[t]; then e=d, d=c, c=rotl30(b), b=a, a=TEMP.
  - All additions are mod 2^32.
  - f and K by round range:
    - t 0-19: f = Ch = (b&c)|(~b&d), K = 5A827999.
    - t 20-39: f = Parity = b^c^d, K = 6ED9EBA1.
    - t 40-59: f = Maj, K = 8F1BBCDC.
    - t 60-79: f = Parity, K = CA62C1D6.
  - Schedule uses a 16-entry circular buffer. For t>=16, W[t mod 16] = rotl1(W[t-3]^W[t-8]^W[t-14]^W[t-16]), computed in place.
  - iValid/iInitial are ignored throughout COMPUTE and FINALIZE. Words are dropped, not queued.
- FINALIZE (1 cycle, oReady=0):
  - Hi = Hi + {a..e}i, mod 2^32.
  - oDat takes the new H value on the same edge.
  - "use IV" clears, count = 0, return to LOAD.
  - oReady=1 the following cycle.
- Latency, with the last word captured at edge N:
  - oReady=0 for cycles N+1 .. N+80/UNROLL+1.
  - oDat is valid and oReady=1 from edge N+80/UNROLL+2; for UNROLL=1 that is 81 low cycles.
- oDat is stable between FINALIZE updates and is never observed partially updated.
- Back-to-back: a new word may be accepted in the first oReady=1 cycle.
- Padding is not handled by this block; upstream supplies padded blocks.

Test Plan:
- Reset, then 16 words with iInitial on word 0, W0=80000000, W1..W15=0 -> oReady low 81 cycles; oDat = da39a3ee 5e6b4b0d 3255bfef 95601890 afd80709.
- "abc" block: W0=61626380, W15=00000018, others 0 -> oDat = a9993e36 4706816a ba3e2571 7850c26c 9cd0d89d. Repeat immediately with iInitial on the first oReady cycle -> same digest.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (56 bytes padded to 2 blocks), iInitial on first block only -> 84983e44 1c3bd26e baae4aa1 f95129e5 e54670f1.
- iValid pulses with junk data during COMPUTE -> ignored; digest still matches "abc".
- Assert reset at round 40 -> next cycle oReady=1, oDat=0. A following "abc" block yields the correct digest.
- iInitial reasserted at word 7 with a fresh "abc" block -> correct "abc" digest. UNROLL=4 build: oReady low 21 cycles, same digests.
